// File: rtl/hold_line_pkg.sv
// Shared encodings and limits for the hold-line serial transmitter.
package hold_line_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int   HOLD_MIN  = 10;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/hold_timer.sv
// Per-bit hold counter: counts 0..HOLD-1 while running and flags the last cycle.
module hold_timer
    import hold_line_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int HOLD  = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] count;

    assign expire = run && (count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/hold_line_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB first, stop bit, each held HOLD clocks.
module hold_line_tx
    import hold_line_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int HOLD   = 12,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              q,
    output logic              busy
);
    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    generate
        if (HOLD < HOLD_MIN) begin : g_bad_hold
            $error("hold_line_tx: HOLD must be at least %0d", HOLD_MIN);
        end
        if ((2 ** CNT_W) < HOLD) begin : g_bad_cnt
            $error("hold_line_tx: CNT_W too narrow for HOLD");
        end
        if (DATA_W < 1 || DATA_W > 16) begin : g_bad_width
            $error("hold_line_tx: DATA_W must be 1..16");
        end
    endgenerate

    logic [1:0]        state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              expire;

    assign accept   = valid & ready;
    assign shift_nx = shift >> 1;

    // busy is high exactly while a frame phase is running, so it gates the timer.
    hold_timer #(.CNT_W(CNT_W), .HOLD(HOLD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .run    (busy),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            q     <= LINE_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift <= data;
                        idx   <= '0;
                        state <= ST_START;
                        q     <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        state <= ST_DATA;
                        q     <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shift <= shift_nx;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= ST_STOP;
                            q     <= LINE_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                            q   <= shift_nx[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (expire) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    q     <= LINE_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hold_line_tx.sv
// Randomised bench for hold_line_tx against a frame-position model and a filtered-receiver decode.
module tb_hold_line_tx;
    localparam int DATA_W = 8;
    localparam int HOLD   = 12;
    localparam int CNT_W  = 4;
    localparam int FRAME  = (DATA_W + 2) * HOLD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              ready;
    logic              q;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hold_line_tx #(.DATA_W(DATA_W), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .q     (q),
        .busy  (busy)
    );

    // Model: pos is the cycle offset inside the current frame, -1 when idle.
    int                pos = -1;
    logic [DATA_W-1:0] mword = '0;
    logic [DATA_W-1:0] sent_q[$];

    always @(posedge clk) begin
        if (rst) begin
            pos = -1;
        end else if (pos < 0) begin
            if (valid) begin
                mword = data;
                pos   = 0;
                sent_q.push_back(data);
            end
        end else begin
            pos++;
            if (pos == FRAME) pos = -1;
        end
    end

    // Expected {q, ready, busy} from the frame position.
    function automatic logic [2:0] exp_out();
        int s;
        if (pos < 0) return 3'b110;
        s = pos / HOLD;
        if (s == 0) return 3'b001;
        if (s <= DATA_W) return {mword[s-1], 2'b01};
        return 3'b101;
    endfunction

    logic rec_on = 1'b0;
    logic line_q[$];
    always @(negedge clk) if (rec_on) line_q.push_back(q);

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== 3'b110) begin
                n_bad++;
                $display("FAIL reset_hold: got q/ready/busy=%b expected 110", {q, ready, busy});
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out() || q !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", c, {q, ready, busy}, exp_out());
            end
        end
    endtask

    task automatic test_a5();
        logic [DATA_W+1:0] fv;
        logic              eq;
        logic              er;
        fv    = {1'b1, 8'hA5, 1'b0};
        data  = 8'hA5;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c <= FRAME; c++) begin
            if (c > 0) @(negedge clk);
            eq = (c < FRAME) ? fv[c/HOLD] : 1'b1;
            er = (c == FRAME);
            n_cmp++;
            if (q !== eq || ready !== er || busy !== ~er) begin
                n_bad++;
                $display("FAIL a5_frame cyc %0d: got q=%b ready=%b busy=%b expected q=%b ready=%b", c, q, ready, busy, eq, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ready_hi;
        int zeros;
        ready_hi = 0;
        zeros    = 0;
        data     = 8'h00;
        valid    = 1'b1;
        @(negedge clk);
        data = 8'hFF;
        for (int c = 0; c <= 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out()) begin
                n_bad++;
                $display("FAIL b2b cyc %0d: got %b expected %b", c, {q, ready, busy}, exp_out());
            end
            if (ready === 1'b1) ready_hi++;
            if (c >= FRAME + 1 + HOLD && c < FRAME + 1 + (DATA_W + 1) * HOLD && q !== 1'b1) zeros++;
            if (c == FRAME + 1) valid = 1'b0;
        end
        n_cmp++;
        if (ready_hi !== 1) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d idle cycles expected 1", ready_hi);
        end
        n_cmp++;
        if (zeros !== 0) begin
            n_bad++;
            $display("FAIL b2b_ff_bits: got %0d zero data cycles expected 0", zeros);
        end
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out()) begin
                n_bad++;
                $display("FAIL b2b_drain: got %b expected %b", {q, ready, busy}, exp_out());
            end
        end
    endtask

    task automatic test_reset_mid();
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 4 * HOLD + 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out()) begin
                n_bad++;
                $display("FAIL mid_pre cyc %0d: got %b expected %b", c, {q, ready, busy}, exp_out());
            end
        end
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h55;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        n_cmp++;
        if ({q, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_reset: got q/ready/busy=%b expected 110", {q, ready, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({q, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_reset_no_accept: got %b expected 110", {q, ready, busy});
        end
        data  = 8'h81;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < FRAME + 3; c++) begin
            if (c > 0) @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out()) begin
                n_bad++;
                $display("FAIL mid_81 cyc %0d: got %b expected %b", c, {q, ready, busy}, exp_out());
            end
        end
    endtask

    task automatic test_busy_noise();
        int n_before;
        n_before = sent_q.size();
        data     = DATA_W'($urandom);
        valid    = 1'b1;
        @(negedge clk);
        for (int c = 0; c < FRAME + 20; c++) begin
            if (c > 0) @(negedge clk);
            n_cmp++;
            if ({q, ready, busy} !== exp_out()) begin
                n_bad++;
                $display("FAIL noise cyc %0d: got %b expected %b", c, {q, ready, busy}, exp_out());
            end
            data  = DATA_W'($urandom);
            valid = (pos >= 0) ? 1'($urandom) : 1'b0;
        end
        valid = 1'b0;
        n_cmp++;
        if (sent_q.size() - n_before !== 1) begin
            n_bad++;
            $display("FAIL noise_frames: got %0d frames expected 1", sent_q.size() - n_before);
        end
    endtask

    task automatic test_loopback();
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] got[$];
        logic              filt[$];
        logic              f;
        int                cnt;
        int                run;
        int                min_run;
        int                i;
        int                base;
        logic [DATA_W-1:0] w;
        logic              stop_ok;

        line_q.delete();
        rec_on = 1'b1;
        for (int k = 0; k < 100; k++) begin
            w     = DATA_W'($urandom);
            words.push_back(w);
            data  = w;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            for (int c = 0; c < FRAME + 5 && pos >= 0; c++) begin
                n_cmp++;
                if ({q, ready, busy} !== exp_out()) begin
                    n_bad++;
                    $display("FAIL loop w%0d cyc %0d: got %b expected %b", k, c, {q, ready, busy}, exp_out());
                end
                @(negedge clk);
            end
            n_cmp++;
            if (pos >= 0) begin
                n_bad++;
                $display("FAIL loop_timeout w%0d: frame did not end, pos=%0d expected -1", k, pos);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        rec_on = 1'b0;

        min_run = 1 << 30;
        run     = 0;
        for (int j = 1; j < line_q.size(); j++) begin
            run++;
            if (line_q[j] !== line_q[j-1]) begin
                if (j - run > 0 && run < min_run) min_run = run;
                run = 0;
            end
        end
        n_cmp++;
        if (min_run < HOLD) begin
            n_bad++;
            $display("FAIL pulse_width: got min %0d cycles expected >= %0d", min_run, HOLD);
        end

        f   = 1'b1;
        cnt = 0;
        foreach (line_q[j]) begin
            if (line_q[j] !== f) begin
                cnt++;
                if (cnt >= 9) begin
                    f   = line_q[j];
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            filt.push_back(f);
        end

        i = 1;
        while (i < filt.size()) begin
            if (filt[i-1] === 1'b1 && filt[i] === 1'b0) begin
                base = i + HOLD / 2;
                if (base + (DATA_W + 1) * HOLD >= filt.size()) break;
                for (int b = 0; b < DATA_W; b++) w[b] = filt[base + (b + 1) * HOLD];
                stop_ok = filt[base + (DATA_W + 1) * HOLD];
                n_cmp++;
                if (stop_ok !== 1'b1) begin
                    n_bad++;
                    $display("FAIL loop_stop frame %0d: got %b expected 1", got.size(), stop_ok);
                end
                got.push_back(w);
                i = base + (DATA_W + 1) * HOLD;
            end else begin
                i++;
            end
        end

        n_cmp++;
        if (got.size() !== words.size()) begin
            n_bad++;
            $display("FAIL loop_count: got %0d words expected %0d", got.size(), words.size());
        end
        foreach (words[k]) begin
            if (k < got.size()) begin
                n_cmp++;
                if (got[k] !== words[k]) begin
                    n_bad++;
                    $display("FAIL loop_word %0d: got %h expected %h", k, got[k], words[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        repeat (3) @(negedge clk);
        test_back_to_back();
        test_reset_mid();
        test_busy_noise();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
